// File: rtl/id_pkg.sv
// Shared types and character-class helpers for the identifier stream arbiter.
// Imported by the scan core and the arbiter top level.
package id_pkg;

  localparam int CHAR_W = 8;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    LETTER = 2'd1,
    DIGIT  = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    STREAM = 2'd1,
    REPORT = 2'd2
  } ctrl_state_e;

  function automatic logic is_letter(input logic [CHAR_W-1:0] c);
    return ((c >= "a") && (c <= "z")) || ((c >= "A") && (c <= "Z"));
  endfunction

  function automatic logic is_digit(input logic [CHAR_W-1:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  // LETTER and DIGIT react identically to the next character; only IDLE_S
  // ignores digits, which is what makes a leading number not an identifier.
  function automatic scan_state_e scan_next(input scan_state_e s,
                                            input logic [CHAR_W-1:0] c);
    scan_state_e n;
    n = IDLE_S;
    case (s)
      IDLE_S:         n = is_letter(c) ? LETTER : IDLE_S;
      LETTER, DIGIT: begin
        if (is_digit(c))       n = DIGIT;
        else if (is_letter(c)) n = LETTER;
        else                   n = IDLE_S;
      end
      default:        n = IDLE_S;
    endcase
    return n;
  endfunction

endpackage : id_pkg

// File: rtl/id_scan_core.sv
// Letter/digit recognizer with a saturating LETTER->DIGIT transition counter.
// Cleared at each grant, advanced only on accepted characters.
module id_scan_core
  import id_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic [CHAR_W-1:0] char,
  output scan_state_e       state,
  output logic [CW-1:0]     count
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  scan_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    if (clr) begin
      state_d = IDLE_S;
      count_d = '0;
    end else if (adv) begin
      state_d = scan_next(state_q, char);
      if ((state_q == LETTER) && (state_d == DIGIT) && (count_q != CNT_MAX)) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE_S;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state = state_q;
  assign count = count_q;

endmodule : id_scan_core

// File: rtl/id_stream_arbiter.sv
// Round-robin arbiter granting whole character strings to one shared
// identifier scanner, with a valid/ready per-string result port.
module id_stream_arbiter
  import id_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int CW   = 8,
  localparam int SW   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [CHAR_W*NREQ-1:0]   req_char,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SW-1:0]            res_src,
  output logic                     res_match,
  output logic [CW-1:0]            res_count
);

  ctrl_state_e       ctrl_q, ctrl_d;
  logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]     grant_q, grant_d;
  logic [SW-1:0]     res_src_q, res_src_d;
  logic              res_match_q, res_match_d;
  logic [CW-1:0]     res_count_q, res_count_d;

  logic [SW:0]       pick;
  logic              pick_any;
  logic [SW-1:0]     pick_idx;
  logic              do_grant;
  logic              accept;
  logic              in_report;
  logic [CHAR_W-1:0] cur_char;
  scan_state_e       scan_state;
  logic [CW-1:0]     scan_count;

  // Returns {found, index} of the first valid requester at or above ptr,
  // wrapping; iterating from the far end lets the nearest hit win.
  function automatic logic [SW:0] rr_pick(input logic [NREQ-1:0] v,
                                          input logic [SW-1:0]   ptr);
    logic [SW:0] res;
    int          idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (v[idx]) res = {1'b1, SW'(idx)};
    end
    return res;
  endfunction

  assign pick      = rr_pick(req_valid, rr_ptr_q);
  assign pick_any  = pick[SW];
  assign pick_idx  = pick[SW-1:0];
  assign do_grant  = (ctrl_q == ARB) && pick_any;
  assign cur_char  = req_char[int'(grant_q)*CHAR_W +: CHAR_W];
  assign accept    = (ctrl_q == STREAM) && req_valid[grant_q];
  assign in_report = (ctrl_q == REPORT);

  id_scan_core #(
    .CW (CW)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (do_grant),
    .adv   (accept),
    .char  (cur_char),
    .state (scan_state),
    .count (scan_count)
  );

  // Controller: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= ARB;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // Controller: next state
  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      ARB:     if (pick_any) ctrl_d = STREAM;
      STREAM:  if (accept && req_last[grant_q]) ctrl_d = REPORT;
      REPORT:  if (res_ready) ctrl_d = ARB;
      default: ctrl_d = ARB;
    endcase
  end

  // Controller: outputs, decoded from registered state only. During REPORT the
  // scanner is frozen, so its registered state is the string's final result.
  always_comb begin
    req_ready = '0;
    if (ctrl_q == STREAM) req_ready[grant_q] = 1'b1;
    res_valid = in_report;
    res_src   = in_report ? grant_q              : res_src_q;
    res_match = in_report ? (scan_state == DIGIT) : res_match_q;
    res_count = in_report ? scan_count           : res_count_q;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    res_src_d   = res_src_q;
    res_match_d = res_match_q;
    res_count_d = res_count_q;
    if (do_grant) begin
      grant_d  = pick_idx;
      rr_ptr_d = (pick_idx == SW'(NREQ - 1)) ? '0 : pick_idx + SW'(1);
    end
    // Result registers keep the reported values once REPORT is left.
    if (in_report) begin
      res_src_d   = grant_q;
      res_match_d = (scan_state == DIGIT);
      res_count_d = scan_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      res_src_q   <= '0;
      res_match_q <= 1'b0;
      res_count_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      res_src_q   <= res_src_d;
      res_match_q <= res_match_d;
      res_count_q <= res_count_d;
    end
  end

endmodule : id_stream_arbiter

// File: tb/tb_id_stream_arbiter.sv
// Randomized, self-checking bench for id_stream_arbiter against a
// string-level reference model of the identifier rules.
module tb_id_stream_arbiter;

  localparam int NREQ = 2;
  localparam int CW   = 8;
  localparam int SW   = $clog2(NREQ);
  localparam int CMAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [8*NREQ-1:0]    req_char;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [SW-1:0]        res_src;
  logic                 res_match;
  logic [CW-1:0]        res_count;

  int checks = 0;
  int errors = 0;

  id_stream_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_char  (req_char),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_src   (res_src),
    .res_match (res_match),
    .res_count (res_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit tb_letter(input byte c);
    return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a);
  endfunction

  function automatic bit tb_digit(input byte c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  // String-level rules: count = number of adjacent (letter, digit) pairs;
  // match = string ends in a digit and its trailing alphanumeric run holds a letter.
  function automatic void model(input string s, output logic m, output logic [CW-1:0] c);
    int pairs;
    bit prev_l, run_l, last_d, l, d;
    pairs = 0; prev_l = 0; run_l = 0; last_d = 0;
    for (int i = 0; i < s.len(); i++) begin
      l = tb_letter(s[i]);
      d = tb_digit(s[i]);
      if (d && prev_l) pairs++;
      if (l) run_l = 1;
      else if (!d) run_l = 0;
      prev_l = l;
      last_d = d;
    end
    m = last_d && run_l;
    c = (pairs > CMAX) ? CW'(CMAX) : CW'(pairs);
  endfunction

  task automatic apply_reset();
    req_valid = '0; req_last = '0; req_char = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives string s on requester src from a post-edge drive point; returns at the
  // drive point after the final character was accepted.
  task automatic push_string(input int src, input string s, input bit mark_last,
                             input int gap_pct, input bit noise,
                             output int stray, output bit tmo);
    bit started, acc;
    int n;
    stray = 0; tmo = 0; started = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        req_valid[src] = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          for (int j = 0; j < NREQ; j++) if (j != src && req_ready[j]) stray++;
          @(posedge clk); #1;
        end
      end
      req_valid[src]        = 1'b1;
      req_char[src*8 +: 8]  = s[i];
      req_last[src]         = mark_last && (i == s.len() - 1);
      n = 0;
      do begin
        @(negedge clk);
        for (int j = 0; j < NREQ; j++) if (j != src && req_ready[j]) stray++;
        acc = req_ready[src] && req_valid[src];
        @(posedge clk); #1;
        if (acc) started = 1;
        if (noise && started) begin
          for (int j = 0; j < NREQ; j++) if (j != src) begin
            req_valid[j]       = 1'($urandom_range(1));
            req_last[j]        = 1'($urandom_range(1));
            req_char[j*8 +: 8] = 8'($urandom);
          end
        end
        n++;
      end while (!acc && n < 300);
      if (!acc) begin
        tmo = 1;
        break;
      end
    end
    req_valid[src] = 1'b0;
    req_last[src]  = 1'b0;
    if (noise) for (int j = 0; j < NREQ; j++) if (j != src) begin
      req_valid[j] = 1'b0;
      req_last[j]  = 1'b0;
    end
  endtask

  task automatic test_reset();
    req_valid = '0; req_last = '0; req_char = '0; res_ready = 1'b1;
    rst_n = 1'b0;
    #3;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if ({res_src, res_match, res_count} !== '0) begin errors++;
      $display("FAIL reset_res_fields: got src %0d match %b count %0d want 0", res_src, res_match, res_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== '0 || res_valid !== 1'b0) begin errors++;
      $display("FAIL idle_outputs: got ready %b valid %b want 0 0", req_ready, res_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int stray; bit tmo; logic em; logic [CW-1:0] ec;
    model("a1", em, ec);
    res_ready = 1'b1;
    req_valid[0] = 1'b1; req_char[7:0] = "a"; req_last[0] = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL arb_cycle_ready: got %b want 00", req_ready); end
    @(posedge clk); #1;
    push_string(0, "a1", 1, 0, 0, stray, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL basic_timeout: got timeout want accept"); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_rise: got %b want 1", res_valid); end
    checks++; if (res_src !== SW'(0) || res_match !== em || res_count !== ec) begin errors++;
      $display("FAIL basic_result: got src %0d match %b count %0d want 0 %b %0d", res_src, res_match, res_count, em, ec); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b want 0", res_valid); end
    checks++; if (res_match !== em || res_count !== ec) begin errors++;
      $display("FAIL basic_hold: got match %b count %0d want %b %0d", res_match, res_count, em, ec); end
    @(posedge clk); #1;
  endtask

  task automatic test_mixed();
    int stray; bit tmo; logic em; logic [CW-1:0] ec;
    model("ab12 x9_", em, ec);
    res_ready = 1'b1;
    push_string(0, "ab12 x9_", 1, 30, 1, stray, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL mixed_timeout: got timeout want accept"); end
    checks++; if (stray != 0) begin errors++; $display("FAIL mixed_other_ready: got %0d cycles want 0", stray); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_src !== SW'(0) || res_match !== em || res_count !== ec) begin errors++;
      $display("FAIL mixed_result: got v %b src %0d match %b count %0d want 1 0 %b %0d",
               res_valid, res_src, res_match, res_count, em, ec); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int g[$]; int gc[$]; int r[$]; logic [CW:0] rv[$];
    logic em; logic [CW-1:0] ec;
    apply_reset();
    res_ready = 1'b1;
    req_char = {8'h6b, 8'h35};
    req_last = '1;
    req_valid = '1;
    for (int c = 0; c < 60 && r.size() < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL b2b_first_arb: got %b want 00", req_ready); end
      end
      if (req_ready != '0) begin g.push_back(req_ready[1] ? 1 : 0); gc.push_back(c); end
      if (res_valid) begin r.push_back(int'(res_src)); rv.push_back({res_match, res_count}); end
      @(posedge clk); #1;
      if (g.size() >= 6) req_valid = '0;
    end
    checks++; if (g.size() != 6 || r.size() != 6) begin errors++;
      $display("FAIL b2b_counts: got grants %0d results %0d want 6 6", g.size(), r.size()); end
    for (int i = 0; i < g.size() && i < 6; i++) begin
      checks++; if (g[i] != i % 2) begin errors++; $display("FAIL b2b_grant_order[%0d]: got %0d want %0d", i, g[i], i % 2); end
      if (i > 0) begin
        checks++; if (gc[i] - gc[i-1] != 3) begin errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, gc[i] - gc[i-1]); end
      end
    end
    for (int i = 0; i < r.size() && i < 6; i++) begin
      model((i % 2 == 0) ? "5" : "k", em, ec);
      checks++; if (r[i] != i % 2 || rv[i] !== {em, ec}) begin errors++;
        $display("FAIL b2b_result[%0d]: got src %0d m/c %0h want %0d %0h", i, r[i], rv[i], i % 2, {em, ec}); end
    end
  endtask

  task automatic test_backpressure();
    int stray; bit tmo; logic em; logic [CW-1:0] ec; logic e1m; logic [CW-1:0] e1c;
    model("a1b2", em, ec);
    model("Q", e1m, e1c);
    res_ready = 1'b0;
    req_valid[1] = 1'b1; req_char[15:8] = "Q"; req_last[1] = 1'b1;
    push_string(0, "a1b2", 1, 0, 0, stray, tmo);
    checks++; if (tmo || stray != 0) begin errors++; $display("FAIL bp_stream: got tmo %b stray %0d want 0 0", tmo, stray); end
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      checks++; if (res_valid !== 1'b1 || req_ready !== '0 || res_src !== SW'(0) || res_match !== em || res_count !== ec) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v %b rdy %b src %0d m %b c %0d want 1 00 0 %b %0d",
                 k, res_valid, req_ready, res_src, res_match, res_count, em, ec); end
      @(posedge clk); #1;
      if (k < 5) @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_handshake: got %b want 1", res_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || req_ready !== '0) begin errors++;
      $display("FAIL bp_arb: got v %b rdy %b want 0 00", res_valid, req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b want 10", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0; req_last[1] = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_src !== SW'(1) || res_match !== e1m || res_count !== e1c) begin errors++;
      $display("FAIL bp_req1_result: got v %b src %0d m %b c %0d want 1 1 %b %0d",
               res_valid, res_src, res_match, res_count, e1m, e1c); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    string s; int stray; bit tmo; logic em; logic [CW-1:0] ec;
    s = "";
    for (int i = 0; i < 300; i++) s = {s, "z9"};
    model(s, em, ec);
    res_ready = 1'b1;
    push_string(0, s, 1, 0, 0, stray, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL sat_timeout: got timeout want accept"); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_match !== em || res_count !== ec) begin errors++;
      $display("FAIL sat_result: got v %b m %b c %0d want 1 %b %0d", res_valid, res_match, res_count, em, ec); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int stray; bit tmo; bit seen; logic em; logic [CW-1:0] ec;
    res_ready = 1'b1;
    push_string(0, "abc", 0, 0, 0, stray, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL rmid_timeout: got timeout want accept"); end
    req_valid[0] = 1'b1; req_char[7:0] = "1";
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== '0 || res_valid !== 1'b0 || res_src !== '0 || res_match !== 1'b0 || res_count !== '0) begin
      errors++;
      $display("FAIL rmid_async: got rdy %b v %b src %0d m %b c %0d want all 0",
               req_ready, res_valid, res_src, res_match, res_count); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (res_valid || req_ready != '0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rmid_no_result: got activity want none"); end
    @(posedge clk); #1;
    model("q5", em, ec);
    push_string(0, "q5", 1, 0, 0, stray, tmo);
    @(negedge clk);
    checks++; if (tmo || res_valid !== 1'b1 || res_src !== SW'(0) || res_match !== em || res_count !== ec) begin errors++;
      $display("FAIL rmid_fresh: got v %b src %0d m %b c %0d want 1 0 %b %0d", res_valid, res_src, res_match, res_count, em, ec); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    string pool_o; string s; int src, len, dly, stray; bit tmo; logic em; logic [CW-1:0] ec;
    pool_o = " _-.!@";
    for (int it = 0; it < 40; it++) begin
      src = int'($urandom_range(NREQ - 1));
      len = int'($urandom_range(1, 10));
      s = "";
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(2))
          0:       s = {s, string'(8'($urandom_range(0, 1) ? 8'h61 + $urandom_range(25) : 8'h41 + $urandom_range(25)))};
          1:       s = {s, string'(8'(8'h30 + $urandom_range(9)))};
          default: s = {s, string'(pool_o[$urandom_range(5)])};
        endcase
      end
      model(s, em, ec);
      dly = int'($urandom_range(0, 3));
      res_ready = (dly == 0);
      push_string(src, s, 1, 20, 1, stray, tmo);
      checks++; if (tmo || stray != 0) begin errors++;
        $display("FAIL rand_stream[%0d]: got tmo %b stray %0d want 0 0", it, tmo, stray); end
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_src !== SW'(src) || res_match !== em || res_count !== ec) begin errors++;
        $display("FAIL rand_result[%0d] \"%s\": got v %b src %0d m %b c %0d want 1 %0d %b %0d",
                 it, s, res_valid, res_src, res_match, res_count, src, em, ec); end
      if (dly > 0) begin
        repeat (dly) begin @(posedge clk); #1; end
        res_ready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_id_stream_arbiter
